// File: rtl/vga_tile_grid_engine.sv
// Tile-map renderer with built-in VGA timing: a COLS x ROWS grid of ROM-backed
// tiles, with per-slot tile ids double-buffered and swapped at each frame boundary.
module vga_tile_grid_engine #(
  parameter int          COLS     = 3,
  parameter int          ROWS     = 3,
  parameter int          TILE_W   = 130,
  parameter int          TILE_H   = 130,
  parameter int          X0       = 1,
  parameter int          Y0       = 1,
  parameter int          ADDR_W   = 20,
  parameter int          ROM_LAT  = 1,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FRONT  = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BACK   = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FRONT  = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BACK   = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_slot,
  input  logic [15:0]       wr_tile,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int          NSLOT = COLS * ROWS;
  localparam int          SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int          TXW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int          TYW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned LAT   = ROM_LAT;

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] GX_BEG = 10'(X0);
  localparam logic [9:0] GX_END = 10'(X0 + COLS * TILE_W);
  localparam logic [9:0] GY_BEG = 10'(Y0);
  localparam logic [9:0] GY_END = 10'(Y0 + ROWS * TILE_H);

  localparam logic [TXW-1:0]    TX_LAST   = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0]    TY_LAST   = TYW'(TILE_H - 1);
  localparam logic [8:0]        COLS_W    = 9'(COLS);
  localparam logic [8:0]        NSLOT_W   = 9'(NSLOT);
  localparam logic [ADDR_W-1:0] TILE_W_A  = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] TILE_AREA = ADDR_W'(TILE_W * TILE_H);
  // {hs, vs, active, in_grid, blank}
  localparam logic [4:0]        FL_RST    = 5'b11001;

  logic [9:0]        h_cnt, v_cnt, h_nx, v_nx;
  logic [15:0]       shadow [NSLOT];
  logic [15:0]       active [NSLOT];

  logic              in_x, in_y, blank;
  logic [TXW-1:0]    tx;
  logic [4:0]        col;
  logic [TYW-1:0]    ty;
  logic [8:0]        row_slot;
  logic [ADDR_W-1:0] line_off, base;

  logic              in_x_n, in_y_n, blank_n, cross_n;
  logic [TXW-1:0]    tx_n;
  logic [4:0]        col_n;
  logic [TYW-1:0]    ty_n;
  logic [8:0]        row_slot_n, slot_n;
  logic [ADDR_W-1:0] line_off_n, base_n, addr_n;
  logic [15:0]       id_n;

  logic [4:0]        flags_c, fl;
  logic [4:0]        dly [ROM_LAT];
  logic [11:0]       pix_c;

  // Tile tracking is evaluated on the next counter values so rom_addr is
  // registered in the same cycle the counters reach the pixel it belongs to.
  always_comb begin
    h_nx = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
    v_nx = v_cnt;
    if (h_cnt == H_LAST) v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    in_x_n = (h_nx >= GX_BEG) && (h_nx < GX_END);
    in_y_n = (v_nx >= GY_BEG) && (v_nx < GY_END);

    tx_n    = tx;
    col_n   = col;
    cross_n = 1'b0;
    if (h_nx == GX_BEG) begin
      tx_n    = '0;
      col_n   = '0;
      cross_n = 1'b1;
    end else if (in_x_n) begin
      if (tx == TX_LAST) begin
        tx_n    = '0;
        col_n   = col + 5'd1;
        cross_n = 1'b1;
      end else begin
        tx_n = tx + TXW'(1);
      end
    end

    ty_n       = ty;
    row_slot_n = row_slot;
    line_off_n = line_off;
    if (h_cnt == H_LAST) begin
      if (v_nx == GY_BEG) begin
        ty_n       = '0;
        row_slot_n = '0;
        line_off_n = '0;
      end else if (in_y_n) begin
        if (ty == TY_LAST) begin
          ty_n       = '0;
          row_slot_n = row_slot + COLS_W;
          line_off_n = '0;
        end else begin
          ty_n       = ty + TYW'(1);
          line_off_n = line_off + TILE_W_A;
        end
      end
    end

    slot_n = row_slot_n + {4'b0, col_n};
    id_n   = '0;
    if (slot_n < NSLOT_W) id_n = active[slot_n[SW-1:0]];
    base_n  = base;
    blank_n = blank;
    if (cross_n) begin
      blank_n = (id_n == '0);
      base_n  = ADDR_W'(id_n - 16'd1) * TILE_AREA;
    end
    addr_n = base_n + line_off_n + ADDR_W'(tx_n);
  end

  always_comb begin
    flags_c = {!((h_cnt >= HS_BEG) && (h_cnt < HS_END)),
               !((v_cnt >= VS_BEG) && (v_cnt < VS_END)),
               (h_cnt < HA) && (v_cnt < VA),
               in_x && in_y,
               blank};
    fl    = dly[LAT-1];
    pix_c = '0;
    if (fl[2]) pix_c = (fl[1] && !fl[0]) ? rom_data : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      in_x        <= (X0 == 0);
      in_y        <= (Y0 == 0);
      blank       <= 1'b1;
      tx          <= '0;
      col         <= '0;
      ty          <= '0;
      row_slot    <= '0;
      line_off    <= '0;
      base        <= '0;
      rom_addr    <= '0;
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      for (int unsigned i = 0; i < LAT; i++) dly[i] <= FL_RST;
    end else begin
      h_cnt       <= h_nx;
      v_cnt       <= v_nx;
      in_x        <= in_x_n;
      in_y        <= in_y_n;
      blank       <= blank_n;
      tx          <= tx_n;
      col         <= col_n;
      ty          <= ty_n;
      row_slot    <= row_slot_n;
      line_off    <= line_off_n;
      base        <= base_n;
      frame_start <= (h_nx == '0) && (v_nx == VA);
      if (in_x_n && in_y_n && !blank_n) rom_addr <= addr_n;

      // Swap reads the pre-edge shadow, so a same-clock write waits a frame.
      if (h_cnt == '0 && v_cnt == VA)
        for (int unsigned i = 0; i < NSLOT; i++) active[i] <= shadow[i];
      if (wr_en && ({1'b0, wr_slot} < NSLOT_W)) shadow[wr_slot[SW-1:0]] <= wr_tile;

      dly[0] <= flags_c;
      for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      hsync <= fl[4];
      vsync <= fl[3];
      vga_r <= pix_c[11:8];
      vga_g <= pix_c[7:4];
      vga_b <= pix_c[3:0];
    end
  end

endmodule

// File: tb/tb_vga_tile_grid_engine.sv
// Bench for vga_tile_grid_engine: a default instance (full 640x480 timing) and a
// shrunken-timing instance (ROM_LAT=2) checked every clock against a pixel-level model.
module tb_vga_tile_grid_engine;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_n, wr_en;
  logic [7:0]  wr_slot;
  logic [15:0] wr_tile;

  logic [19:0] rom_addr_a, rom_addr_b;
  logic [11:0] rom_data_a, rom_data_b, rdb1;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_tile_grid_engine u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_slot(wr_slot), .wr_tile(wr_tile),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .hsync(hs_a), .vsync(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
  );

  vga_tile_grid_engine #(
    .COLS(4), .ROWS(3), .TILE_W(6), .TILE_H(5), .X0(3), .Y0(2), .ADDR_W(20),
    .ROM_LAT(2), .BG_COLOR(12'h5A3),
    .H_ACTIVE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_slot(wr_slot), .wr_tile(wr_tile),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .hsync(hs_b), .vsync(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    return 12'(a ^ (a >> 7)) ^ 12'h9C3;
  endfunction

  // Image ROM models with the latency each instance is configured for
  always @(posedge clk) begin
    rom_data_a <= rom_fn(rom_addr_a);
    rdb1       <= rom_fn(rom_addr_b);
    rom_data_b <= rdb1;
  end

  typedef struct packed {
    int cols; int rows; int tw; int th; int x0; int y0; int lat;
    int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp;
    logic [11:0] bg;
  } cfg_t;

  cfg_t        cfg [2];
  int          n [2];
  logic [15:0] sh [2][256];
  logic [15:0] ac [2][256];
  logic [19:0] ea [2];
  int          vectors = 0;
  int          miscompares = 0;

  logic        hs_o [2], vs_o [2], fs_o [2];
  logic [11:0] rgb_o [2];
  logic [19:0] ra_o [2];
  assign hs_o[0] = hs_a;  assign hs_o[1] = hs_b;
  assign vs_o[0] = vs_a;  assign vs_o[1] = vs_b;
  assign fs_o[0] = fs_a;  assign fs_o[1] = fs_b;
  assign rgb_o[0] = {r_a, g_a, b_a};
  assign rgb_o[1] = {r_b, g_b, b_b};
  assign ra_o[0] = rom_addr_a;
  assign ra_o[1] = rom_addr_b;

  function automatic int htot(input int k);
    return cfg[k].ha + cfg[k].hfp + cfg[k].hsw + cfg[k].hbp;
  endfunction
  function automatic int vtot(input int k);
    return cfg[k].va + cfg[k].vfp + cfg[k].vsw + cfg[k].vbp;
  endfunction
  function automatic bit in_grid(input int k, input int h, input int v);
    return h >= cfg[k].x0 && h < cfg[k].x0 + cfg[k].cols * cfg[k].tw &&
           v >= cfg[k].y0 && v < cfg[k].y0 + cfg[k].rows * cfg[k].th;
  endfunction
  function automatic int slot_of(input int k, input int h, input int v);
    return ((v - cfg[k].y0) / cfg[k].th) * cfg[k].cols + (h - cfg[k].x0) / cfg[k].tw;
  endfunction
  function automatic logic [19:0] addr_of(input int k, input int h, input int v, input int id);
    return 20'((id - 1) * cfg[k].tw * cfg[k].th + ((v - cfg[k].y0) % cfg[k].th) * cfg[k].tw
               + (h - cfg[k].x0) % cfg[k].tw);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What one clock edge does to the frame-level state of instance k
  task automatic edge_model(input int k, input logic r, input logic we,
                            input logic [7:0] ws, input logic [15:0] wt);
    int h, v, id;
    if (!r) begin
      n[k]  = 0;
      ea[k] = '0;
      for (int i = 0; i < 256; i++) begin
        sh[k][i] = '0;
        ac[k][i] = '0;
      end
      return;
    end
    h = n[k] % htot(k);
    v = (n[k] / htot(k)) % vtot(k);
    if (h == 0 && v == cfg[k].va)
      for (int i = 0; i < 256; i++) ac[k][i] = sh[k][i];
    if (we && int'(ws) < cfg[k].cols * cfg[k].rows) sh[k][ws] = wt;
    n[k]++;
    h = n[k] % htot(k);
    v = (n[k] / htot(k)) % vtot(k);
    if (in_grid(k, h, v)) begin
      id = int'(ac[k][slot_of(k, h, v)]);
      if (id != 0) ea[k] = addr_of(k, h, v, id);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int p, h, v, id;
      logic ehs, evs, efs;
      logic [11:0] ergb;
      string pfx;
      pfx  = (k == 0) ? "A" : "B";
      p    = n[k] - cfg[k].lat - 1;
      ehs  = 1'b1;
      evs  = 1'b1;
      ergb = '0;
      if (p >= 0) begin
        h   = p % htot(k);
        v   = (p / htot(k)) % vtot(k);
        ehs = !(h >= cfg[k].ha + cfg[k].hfp && h < cfg[k].ha + cfg[k].hfp + cfg[k].hsw);
        evs = !(v >= cfg[k].va + cfg[k].vfp && v < cfg[k].va + cfg[k].vfp + cfg[k].vsw);
        if (h < cfg[k].ha && v < cfg[k].va) begin
          ergb = cfg[k].bg;
          if (in_grid(k, h, v)) begin
            id = int'(ac[k][slot_of(k, h, v)]);
            if (id != 0) ergb = rom_fn(addr_of(k, h, v, id));
          end
        end
      end
      efs = (n[k] % htot(k) == 0) && ((n[k] / htot(k)) % vtot(k) == cfg[k].va);
      chk({pfx, ".hsync"},       32'(hs_o[k]),  32'(ehs));
      chk({pfx, ".vsync"},       32'(vs_o[k]),  32'(evs));
      chk({pfx, ".rgb"},         32'(rgb_o[k]), 32'(ergb));
      chk({pfx, ".rom_addr"},    32'(ra_o[k]),  32'(ea[k]));
      chk({pfx, ".frame_start"}, 32'(fs_o[k]),  32'(efs));
    end
  endtask

  task automatic tick();
    logic r, we;
    logic [7:0] ws;
    logic [15:0] wt;
    r  = rst_n;
    we = wr_en;
    ws = wr_slot;
    wt = wr_tile;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) edge_model(k, r, we, ws, wt);
    check_all();
  endtask

  task automatic write_slot(input logic [7:0] s, input logic [15:0] t);
    wr_en   = 1'b1;
    wr_slot = s;
    wr_tile = t;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        wr_en   = 1'b1;
        wr_slot = 8'($urandom_range(0, 15));
        wr_tile = 16'($urandom_range(0, 6));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    bit found;
    cfg[0] = '{cols:3, rows:3, tw:130, th:130, x0:1, y0:1, lat:1,
               ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, bg:12'h000};
    cfg[1] = '{cols:4, rows:3, tw:6, th:5, x0:3, y0:2, lat:2,
               ha:40, hfp:4, hsw:6, hbp:6, va:20, vfp:2, vsw:2, vbp:3, bg:12'h5A3};
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = '0;
    wr_tile = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Mid-frame write: stays invisible until the next swap
    repeat (500) tick();
    write_slot(8'd0, 16'd1);
    repeat (1600) tick();

    write_slot(8'd4, 16'd2);
    repeat (1600) tick();

    // Slot 9 is out of range for A only; slot 200 for both
    write_slot(8'd9, 16'd5);
    write_slot(8'd200, 16'd5);
    repeat (1600) tick();

    run_random(3000);

    // Write presented on the frame_start clock of B
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (fs_b === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("B.frame_start_seen", 32'(found), 32'd1);
    write_slot(8'd5, 16'd3);
    repeat (3100) tick();

    // Reset pulse at B pixel (30,12)
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (n[1] % htot(1) == 30 && (n[1] / htot(1)) % vtot(1) == 12) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("B.reset_point_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_random(4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
